// File: rtl/mc_ctrl_if.sv
// Shared instruction/data memory port between the multi-cycle control unit
// and the memory.
//
// Handshake: the master raises mem_req (and mem_we for a store) and holds it
// until the slave returns mem_ready; the request completes on the cycle in
// which mem_req and mem_ready are both high. mem_ready is ignored while
// mem_req is low.
interface mc_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        output mem_ready
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit for the RV32I core. Each instruction is sequenced
// through IF/ID/EX/MEM/WB over a single memory port. A memory request that
// waits too long for mem_ready parks the unit in TRAP until reset. Retired
// instructions are counted in a wrapping counter.
module mc_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             zero,
    mc_ctrl_if.master        mem,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic             alu_src,
    output logic [5:0]       ext_op,
    output logic [4:0]       alu_op,
    output logic [2:0]       npc_op,
    output logic [1:0]       wd_sel,
    output logic [2:0]       state,
    output logic             retire,
    output logic             illegal,
    output logic             trap,
    output logic [CNT_W-1:0] retired_cnt
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_TRAP = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_NONE,
        C_R,
        C_IARITH,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_JAL,
        C_JALR
    } class_t;

    localparam logic [5:0] EXT_NONE = 6'b000000;
    localparam logic [5:0] EXT_I    = 6'b010000;
    localparam logic [5:0] EXT_S    = 6'b001000;
    localparam logic [5:0] EXT_B    = 6'b000100;
    localparam logic [5:0] EXT_J    = 6'b000001;

    localparam logic [4:0] ALU_NOP = 5'b00000;
    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_SUB = 5'b00100;
    localparam logic [4:0] ALU_OR  = 5'b01101;
    localparam logic [4:0] ALU_AND = 5'b01110;

    localparam logic [2:0] NPC_SEQ  = 3'b000;
    localparam logic [2:0] NPC_BR   = 3'b001;
    localparam logic [2:0] NPC_JAL  = 3'b010;
    localparam logic [2:0] NPC_JALR = 3'b100;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC4 = 2'b10;

    // The wait counter only has to reach TIMEOUT-1.
    localparam int              WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    class_t             cls_q, cls_d;
    logic [4:0]         alu_sel_q, alu_sel_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               trap_q, trap_d;

    class_t             dec_cls;
    logic [4:0]         dec_alu;

    logic mem_req_c, mem_we_c, ir_we_c, pc_we_c, reg_we_c, retire_c, illegal_c;
    logic [2:0] npc_op_c;
    logic [1:0] wd_sel_c;

    // Decode the instruction register into a class and its ALU operation.
    always_comb begin
        dec_cls = C_NONE;
        dec_alu = ALU_NOP;
        case (opcode)
            7'b0110011: begin
                if (funct7 == 7'b0000000 && funct3 == 3'b000) begin
                    dec_cls = C_R; dec_alu = ALU_ADD;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_cls = C_R; dec_alu = ALU_SUB;
                end else if (funct7 == 7'b0000000 && funct3 == 3'b110) begin
                    dec_cls = C_R; dec_alu = ALU_OR;
                end else if (funct7 == 7'b0000000 && funct3 == 3'b111) begin
                    dec_cls = C_R; dec_alu = ALU_AND;
                end
            end
            7'b0010011: begin
                if (funct3 == 3'b000) begin
                    dec_cls = C_IARITH; dec_alu = ALU_ADD;
                end else if (funct3 == 3'b110) begin
                    dec_cls = C_IARITH; dec_alu = ALU_OR;
                end else if (funct3 == 3'b111) begin
                    dec_cls = C_IARITH; dec_alu = ALU_AND;
                end
            end
            7'b0000011: if (funct3 == 3'b010) begin dec_cls = C_LOAD;   dec_alu = ALU_ADD; end
            7'b0100011: if (funct3 == 3'b010) begin dec_cls = C_STORE;  dec_alu = ALU_ADD; end
            7'b1100011: if (funct3 == 3'b000) begin dec_cls = C_BRANCH; dec_alu = ALU_SUB; end
            7'b1101111: begin dec_cls = C_JAL; dec_alu = ALU_NOP; end
            7'b1100111: if (funct3 == 3'b000) begin dec_cls = C_JALR; dec_alu = ALU_ADD; end
            default: ;
        endcase
    end

    // Next-state and sequencing strobes; wait_cnt clears on any state change.
    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        alu_sel_d  = alu_sel_q;
        wait_cnt_d = '0;
        mem_req_c  = 1'b0;
        mem_we_c   = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        reg_we_c   = 1'b0;
        retire_c   = 1'b0;
        illegal_c  = 1'b0;
        npc_op_c   = NPC_SEQ;
        wd_sel_c   = WD_ALU;
        case (state_q)
            S_IF: begin
                mem_req_c = 1'b1;
                if (mem.mem_ready) begin
                    ir_we_c = 1'b1;
                    state_d = S_ID;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_ID: begin
                cls_d     = dec_cls;
                alu_sel_d = dec_alu;
                if (dec_cls == C_NONE) begin
                    // Skip the instruction: step the PC and fetch the next one.
                    illegal_c = 1'b1;
                    pc_we_c   = 1'b1;
                    state_d   = S_IF;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                case (cls_q)
                    C_R, C_IARITH, C_JAL, C_JALR: state_d = S_WB;
                    C_LOAD, C_STORE:              state_d = S_MEM;
                    C_BRANCH: begin
                        pc_we_c  = 1'b1;
                        npc_op_c = zero ? NPC_BR : NPC_SEQ;
                        retire_c = 1'b1;
                        state_d  = S_IF;
                    end
                    default: state_d = S_IF;
                endcase
            end
            S_MEM: begin
                mem_req_c = 1'b1;
                mem_we_c  = (cls_q == C_STORE);
                if (mem.mem_ready) begin
                    if (cls_q == C_STORE) begin
                        pc_we_c  = 1'b1;
                        retire_c = 1'b1;
                        state_d  = S_IF;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_TRAP;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_WB: begin
                reg_we_c = 1'b1;
                pc_we_c  = 1'b1;
                retire_c = 1'b1;
                state_d  = S_IF;
                case (cls_q)
                    C_LOAD:       wd_sel_c = WD_MEM;
                    C_JAL, C_JALR: wd_sel_c = WD_PC4;
                    default:      wd_sel_c = WD_ALU;
                endcase
                case (cls_q)
                    C_JAL:   npc_op_c = NPC_JAL;
                    C_JALR:  npc_op_c = NPC_JALR;
                    default: npc_op_c = NPC_SEQ;
                endcase
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IF;
        endcase
    end

    // Datapath selects follow the latched class for the rest of the instruction.
    always_comb begin
        alu_src = 1'b0;
        ext_op  = EXT_NONE;
        alu_op  = ALU_NOP;
        if (state_q == S_EX || state_q == S_MEM || state_q == S_WB) begin
            alu_op = alu_sel_q;
            case (cls_q)
                C_IARITH, C_LOAD, C_JALR: begin alu_src = 1'b1; ext_op = EXT_I; end
                C_STORE:                  begin alu_src = 1'b1; ext_op = EXT_S; end
                C_BRANCH:                 ext_op = EXT_B;
                C_JAL:                    ext_op = EXT_J;
                default:                  ;
            endcase
        end
    end

    // Architectural writes are suppressed on a reset cycle so an aborted
    // instruction leaves no trace.
    assign mem.mem_req = mem_req_c;
    assign mem.mem_we  = mem_we_c  & ~rst;
    assign ir_we       = ir_we_c   & ~rst;
    assign pc_we       = pc_we_c   & ~rst;
    assign reg_we      = reg_we_c  & ~rst;
    assign retire      = retire_c  & ~rst;
    assign illegal     = illegal_c & ~rst;
    assign npc_op      = npc_op_c;
    assign wd_sel      = wd_sel_c;
    assign state       = state_q;
    assign trap        = trap_q;
    assign retired_cnt = cnt_q;

    // Retire counter wraps naturally; trap is sticky once TRAP is entered.
    always_comb begin
        cnt_d  = retire ? cnt_q + CNT_W'(1) : cnt_q;
        trap_d = trap_q | (state_d == S_TRAP);
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IF;
            cls_q      <= C_NONE;
            alu_sel_q  <= ALU_NOP;
            wait_cnt_q <= '0;
            cnt_q      <= '0;
            trap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            alu_sel_q  <= alu_sel_d;
            wait_cnt_q <= wait_cnt_d;
            cnt_q      <= cnt_d;
            trap_q     <= trap_d;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-instruction state snapshots, latency,
// retire counting with wrap, illegal skip, memory timeout and mid-instruction reset.
module tb_mc_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;

    localparam logic [2:0] ST_IF = 3'd0, ST_ID = 3'd1, ST_EX = 3'd2,
                           ST_MEM = 3'd3, ST_WB = 3'd4, ST_TRAP = 3'd7;

    logic             clk = 1'b0;
    logic             rst;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             zero;
    logic             ir_we, pc_we, reg_we, alu_src, retire, illegal, trap;
    logic [5:0]       ext_op;
    logic [4:0]       alu_op;
    logic [2:0]       npc_op, state;
    logic [1:0]       wd_sel;
    logic [CNT_W-1:0] retired_cnt;

    mc_ctrl_if mem_if ();

    // Clock and reset
    always #5 clk = ~clk;

    mc_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero(zero), .mem(mem_if), .ir_we(ir_we), .pc_we(pc_we), .reg_we(reg_we),
        .alu_src(alu_src), .ext_op(ext_op), .alu_op(alu_op), .npc_op(npc_op),
        .wd_sel(wd_sel), .state(state), .retire(retire), .illegal(illegal),
        .trap(trap), .retired_cnt(retired_cnt)
    );

    typedef struct packed {
        logic       mem_req, mem_we, ir_we, pc_we, reg_we, alu_src;
        logic [5:0] ext_op;
        logic [4:0] alu_op;
        logic [2:0] npc_op;
        logic [1:0] wd_sel;
        logic       retire, illegal;
    } snap_t;

    snap_t snap [8];
    logic  seen [8];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    exp_cnt;
    int    cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [31:0] ins);
        opcode = ins[6:0];
        funct3 = ins[14:12];
        funct7 = ins[31:25];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_if.mem_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    // Driver: runs one instruction from IF, inserting memory wait cycles,
    // snapshotting outputs per state until retire or illegal.
    task automatic run_instr(input logic [31:0] ins, input int if_wait, input int mem_wait,
                             input logic z, output int cycles);
        int if_n, mem_n;
        logic done;
        logic [2:0] st;
        set_instr(ins);
        zero = z;
        for (int i = 0; i < 8; i++) seen[i] = 1'b0;
        cycles = 0; done = 1'b0; if_n = 0; mem_n = 0;
        while (!done && cycles < 30) begin
            st = state;
            if (st == ST_IF) begin
                mem_if.mem_ready = (if_n >= if_wait); if_n++;
            end else if (st == ST_MEM) begin
                mem_if.mem_ready = (mem_n >= mem_wait); mem_n++;
            end else begin
                mem_if.mem_ready = 1'b1;
            end
            #1;
            snap[st] = {mem_if.mem_req, mem_if.mem_we, ir_we, pc_we, reg_we, alu_src,
                        ext_op, alu_op, npc_op, wd_sel, retire, illegal};
            seen[st] = 1'b1;
            cycles++;
            if (retire || illegal) done = 1'b1;
            tick();
        end
        check_eq("instr_completes", 32'(done), 32'd1);
        check_eq("back_in_if", 32'(state), 32'(ST_IF));
    endtask

    task automatic retire_one();
        exp_cnt = (exp_cnt + 1) % 16;
        check_eq("retired_cnt", 32'(retired_cnt), 32'(exp_cnt));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    // Scoreboard of directed vectors
    initial begin
        rst = 1'b1; zero = 1'b0; mem_if.mem_ready = 1'b0;
        set_instr(32'h0000_0013);
        do_reset();

        check_eq("rst_state",   32'(state), 32'(ST_IF));
        check_eq("rst_mem_req", 32'(mem_if.mem_req), 32'd1);
        check_eq("rst_mem_we",  32'(mem_if.mem_we), 32'd0);
        check_eq("rst_ir_we",   32'(ir_we), 32'd0);
        check_eq("rst_pc_we",   32'(pc_we), 32'd0);
        check_eq("rst_reg_we",  32'(reg_we), 32'd0);
        check_eq("rst_retire",  32'(retire), 32'd0);
        check_eq("rst_trap",    32'(trap), 32'd0);
        check_eq("rst_cnt",     32'(retired_cnt), 32'd0);

        // add x3,x1,x2
        run_instr(32'h0020_81B3, 0, 0, 1'b0, cyc);
        check_eq("add_cycles", 32'(cyc), 32'd4);
        check_eq("add_if_ir_we", 32'(snap[ST_IF].ir_we), 32'd1);
        check_eq("add_wb_reg_we", 32'(snap[ST_WB].reg_we), 32'd1);
        check_eq("add_wb_wd_sel", 32'(snap[ST_WB].wd_sel), 32'd0);
        check_eq("add_wb_alu_op", 32'(snap[ST_WB].alu_op), 32'b00011);
        check_eq("add_ex_alu_src", 32'(snap[ST_EX].alu_src), 32'd0);
        check_eq("add_no_mem", 32'(seen[ST_MEM]), 32'd0);
        retire_one();
        check_eq("add_cnt_one", 32'(retired_cnt), 32'd1);

        // lw x3,0(x1) with two MEM wait cycles
        run_instr(32'h0000_A183, 0, 2, 1'b0, cyc);
        check_eq("lw_cycles", 32'(cyc), 32'd7);
        check_eq("lw_mem_req", 32'(snap[ST_MEM].mem_req), 32'd1);
        check_eq("lw_mem_we", 32'(snap[ST_MEM].mem_we), 32'd0);
        check_eq("lw_wb_wd_sel", 32'(snap[ST_WB].wd_sel), 32'b01);
        check_eq("lw_wb_ext_op", 32'(snap[ST_WB].ext_op), 32'b010000);
        check_eq("lw_wb_reg_we", 32'(snap[ST_WB].reg_we), 32'd1);
        retire_one();

        // beq taken then not taken
        run_instr(32'h0020_8063, 0, 0, 1'b1, cyc);
        check_eq("beq1_cycles", 32'(cyc), 32'd3);
        check_eq("beq1_npc", 32'(snap[ST_EX].npc_op), 32'b001);
        check_eq("beq1_pc_we", 32'(snap[ST_EX].pc_we), 32'd1);
        check_eq("beq1_reg_we", 32'(snap[ST_EX].reg_we), 32'd0);
        check_eq("beq1_alu_op", 32'(snap[ST_EX].alu_op), 32'b00100);
        check_eq("beq1_ext_op", 32'(snap[ST_EX].ext_op), 32'b000100);
        retire_one();
        run_instr(32'h0020_8063, 0, 0, 1'b0, cyc);
        check_eq("beq0_cycles", 32'(cyc), 32'd3);
        check_eq("beq0_npc", 32'(snap[ST_EX].npc_op), 32'b000);
        check_eq("beq0_pc_we", 32'(snap[ST_EX].pc_we), 32'd1);
        retire_one();

        // sw x2,0(x1)
        run_instr(32'h0020_A023, 0, 0, 1'b0, cyc);
        check_eq("sw_cycles", 32'(cyc), 32'd4);
        check_eq("sw_mem_req", 32'(snap[ST_MEM].mem_req), 32'd1);
        check_eq("sw_mem_we", 32'(snap[ST_MEM].mem_we), 32'd1);
        check_eq("sw_ext_op", 32'(snap[ST_MEM].ext_op), 32'b001000);
        check_eq("sw_retire", 32'(snap[ST_MEM].retire), 32'd1);
        check_eq("sw_reg_we", 32'(snap[ST_MEM].reg_we), 32'd0);
        check_eq("sw_no_wb", 32'(seen[ST_WB]), 32'd0);
        retire_one();

        // Illegal opcode, then a legal instruction is fetched normally
        run_instr(32'h0000_007F, 0, 0, 1'b0, cyc);
        check_eq("ill_cycles", 32'(cyc), 32'd2);
        check_eq("ill_pulse", 32'(snap[ST_ID].illegal), 32'd1);
        check_eq("ill_npc", 32'(snap[ST_ID].npc_op), 32'b000);
        check_eq("ill_pc_we", 32'(snap[ST_ID].pc_we), 32'd1);
        check_eq("ill_reg_we", 32'(snap[ST_ID].reg_we), 32'd0);
        check_eq("ill_retire", 32'(snap[ST_ID].retire), 32'd0);
        check_eq("ill_cnt", 32'(retired_cnt), 32'(exp_cnt));
        run_instr(32'h0020_81B3, 0, 0, 1'b0, cyc);
        check_eq("after_ill_cycles", 32'(cyc), 32'd4);
        retire_one();

        // add with an unsupported funct7 is illegal
        run_instr(32'h2020_81B3, 0, 0, 1'b0, cyc);
        check_eq("bad_f7_illegal", 32'(snap[ST_ID].illegal), 32'd1);
        check_eq("bad_f7_cnt", 32'(retired_cnt), 32'(exp_cnt));

        // jal / jalr
        run_instr(32'h0080_00EF, 0, 0, 1'b0, cyc);
        check_eq("jal_cycles", 32'(cyc), 32'd4);
        check_eq("jal_wd_sel", 32'(snap[ST_WB].wd_sel), 32'b10);
        check_eq("jal_npc", 32'(snap[ST_WB].npc_op), 32'b010);
        check_eq("jal_ext_op", 32'(snap[ST_WB].ext_op), 32'b000001);
        retire_one();
        run_instr(32'h0000_80E7, 0, 0, 1'b0, cyc);
        check_eq("jalr_cycles", 32'(cyc), 32'd4);
        check_eq("jalr_wd_sel", 32'(snap[ST_WB].wd_sel), 32'b10);
        check_eq("jalr_npc", 32'(snap[ST_WB].npc_op), 32'b100);
        check_eq("jalr_alu_src", 32'(snap[ST_WB].alu_src), 32'd1);
        retire_one();

        // addi with one fetch wait cycle, plus sub / or / andi ALU selection
        run_instr(32'h0010_8093, 1, 0, 1'b0, cyc);
        check_eq("addi_cycles", 32'(cyc), 32'd5);
        check_eq("addi_alu_src", 32'(snap[ST_EX].alu_src), 32'd1);
        check_eq("addi_ext_op", 32'(snap[ST_EX].ext_op), 32'b010000);
        check_eq("addi_alu_op", 32'(snap[ST_EX].alu_op), 32'b00011);
        retire_one();
        run_instr(32'h4020_81B3, 0, 0, 1'b0, cyc);
        check_eq("sub_alu_op", 32'(snap[ST_EX].alu_op), 32'b00100);
        retire_one();
        run_instr(32'h0020_E1B3, 0, 0, 1'b0, cyc);
        check_eq("or_alu_op", 32'(snap[ST_EX].alu_op), 32'b01101);
        retire_one();
        run_instr(32'h0010_F093, 0, 0, 1'b0, cyc);
        check_eq("andi_alu_op", 32'(snap[ST_EX].alu_op), 32'b01110);
        retire_one();

        // Reset in WB aborts the instruction with no writes
        set_instr(32'h0020_81B3);
        mem_if.mem_ready = 1'b1;
        tick(); tick(); tick();
        check_eq("abort_in_wb", 32'(state), 32'(ST_WB));
        rst = 1'b1;
        #1;
        check_eq("abort_pc_we", 32'(pc_we), 32'd0);
        check_eq("abort_reg_we", 32'(reg_we), 32'd0);
        check_eq("abort_retire", 32'(retire), 32'd0);
        tick();
        rst = 1'b0;
        check_eq("abort_state", 32'(state), 32'(ST_IF));
        check_eq("abort_cnt", 32'(retired_cnt), 32'd0);

        // Fetch timeout: four IF cycles without mem_ready, then TRAP
        do_reset();
        for (int i = 0; i < TIMEOUT; i++) begin
            check_eq("if_wait_state", 32'(state), 32'(ST_IF));
            tick();
        end
        check_eq("if_trap_state", 32'(state), 32'(ST_TRAP));
        check_eq("if_trap_flag", 32'(trap), 32'd1);
        check_eq("if_trap_mem_req", 32'(mem_if.mem_req), 32'd0);
        mem_if.mem_ready = 1'b1;
        tick(); tick(); tick();
        check_eq("trap_held", 32'(state), 32'(ST_TRAP));
        check_eq("trap_sticky", 32'(trap), 32'd1);
        check_eq("trap_pc_we", 32'(pc_we), 32'd0);
        do_reset();
        check_eq("trap_clr_state", 32'(state), 32'(ST_IF));
        check_eq("trap_clr_flag", 32'(trap), 32'd0);

        // Data timeout in MEM for a load
        set_instr(32'h0000_A183);
        mem_if.mem_ready = 1'b1;
        tick(); tick(); tick();
        check_eq("mem_to_state", 32'(state), 32'(ST_MEM));
        mem_if.mem_ready = 1'b0;
        tick(); tick(); tick();
        check_eq("mem_to_waiting", 32'(state), 32'(ST_MEM));
        tick();
        check_eq("mem_to_trap", 32'(state), 32'(ST_TRAP));
        check_eq("mem_to_flag", 32'(trap), 32'd1);
        check_eq("mem_to_mem_we", 32'(mem_if.mem_we), 32'd0);

        // Counter wrap: 17 retirements on a 4-bit counter
        do_reset();
        for (int i = 0; i < 17; i++) begin
            run_instr(32'h0020_81B3, 0, 0, 1'b0, cyc);
        end
        check_eq("cnt_wrap", 32'(retired_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control unit for the RV32I core; replaces the single-cycle combinational decoder.
- Sequences each instruction through IF/ID/EX/MEM/WB over a shared instruction/data memory port with a ready handshake.
- Drives the same datapath control encodings, adds a configurable memory-timeout trap and a retired-instruction counter.

Parameters:
- TIMEOUT, 16, max cycles a memory request may wait for mem_ready before trapping (>=1).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- opcode  in  7  instr[6:0] from instruction register, valid from ID onward
- funct3  in  3  instr[14:12]
- funct7  in  7  instr[31:25]
- zero  in  1  ALU zero flag, sampled in EX
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request (fetch or data)
- mem_we  out  1  write strobe, only with mem_req in MEM for sw
- ir_we  out  1  load instruction register
- pc_we  out  1  update PC with NPC result
- reg_we  out  1  register file write
- alu_src  out  1  ALU B from immediate
- ext_op  out  6  one-hot: [5] shamt, [4] I, [3] S, [2] B, [1] U, [0] J
- alu_op  out  5  nop 00000, add 00011, sub 00100, or 01101, and 01110
- npc_op  out  3  000 +4, 001 branch, 010 jal, 100 jalr
- wd_sel  out  2  00 ALU, 01 MEM, 10 PC+4
- state  out  3  current state (debug)
- retire  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  one-cycle pulse in ID for unsupported instruction
- trap  out  1  sticky memory-timeout error
- retired_cnt  out  CNT_W  count of retired instructions

Behaviour:
- Synchronous, active-high reset: state=IF, wait counter=0, decode class=none, retired_cnt=0, trap=0. All strobes are combinational from state/class, so all are 0 except mem_req=1 in IF.
- Supported: add, sub, or, and, addi, ori, andi, lw, sw, beq, jal, jalr. Anything else is illegal.
- States and encodings: IF=0, ID=1, EX=2, MEM=3, WB=4, TRAP=7.
- IF:
  - mem_req=1. If mem_ready: ir_we=1, go to ID.
  - Otherwise wait_cnt++. If wait_cnt reaches TIMEOUT-1 without mem_ready, go to TRAP.
- ID:
  - Decode opcode/funct3/funct7 into a registered class: R, I-arith, LOAD, STORE, BRANCH, JAL, JALR.
  - Illegal: illegal=1, pc_we=1 with npc_op=000, no reg/mem writes, retire=0, next state IF.
- EX:
  - ALU/ext/src signals driven per class, same mapping as the single-cycle decoder.
  - R and I-arith go to WB. LOAD and STORE go to MEM.
  - BRANCH: pc_we=1, npc_op=001 if zero else 000, retire=1, go to IF.
  - JAL/JALR: go to WB.
- MEM:
  - mem_req=1; mem_we=1 for STORE only. Timeout rules as in IF; wait_cnt clears on state entry.
  - On mem_ready: LOAD goes to WB; STORE does pc_we=1 (npc 000), retire=1, go to IF.
- WB:
  - reg_we=1, pc_we=1, retire=1, go to IF.
  - wd_sel=01 for LOAD, 10 for JAL/JALR, else 00.
  - npc_op=010 for JAL, 100 for JALR, else 000.
- TRAP: all strobes 0, trap=1, state held until rst.
- Zero-wait latencies (cycles): branch 3, sw 4, R/I/jal/jalr 4, lw 5. Each memory wait cycle adds 1.
- retired_cnt increments on retire and wraps at 2^CNT_W-1 → 0.
- rst asserted mid-instruction aborts it: no pc_we, reg_we or mem_we on the reset cycle; next cycle is IF.
- mem_ready outside IF/MEM is ignored.

Test Plan:
- rst, then add x3,x1,x2 (0x002081B3) with mem_ready tied 1 → states IF,ID,EX,WB; reg_we=1, wd_sel=00, alu_op=00011 in WB; retire pulse at cycle 4; retired_cnt=1.
- lw (0x0000A183) with 2 wait cycles in MEM → 7 cycles total; mem_we=0; WB wd_sel=01, ext_op=010000.
- beq with zero=1, then zero=0 → EX: npc_op=001, then 000; pc_we=1, reg_we=0, 3 cycles each.
- sw (0x0020A023) → MEM: mem_req=1, mem_we=1, ext_op=001000; no WB; retire in MEM.
- Illegal opcode 0x0000007F → illegal pulse in ID, npc_op=000, pc_we=1, retired_cnt unchanged; next instruction is fetched.
- TIMEOUT=4, mem_ready held 0 in IF → TRAP after 4 IF cycles, trap=1 and stays 1; rst returns state to IF, trap=0.
- CNT_W=4, retire 17 instructions → retired_cnt=1 (wrap).
